// File: rtl/sim_cpu_bus_master.sv
// sim_cpu_bus_master
//
// Simulator-side 6510 bus initiator for the VIC-II CPU register port.
// A testbench offers register reads/writes on a valid/ready command port;
// each command is issued as one register access during phi-high, starting
// on the dot4x edge that sees phi rise, and completes with a one-cycle
// rsp_valid pulse. BA/AEC arbitration follows 6510 rules: reads stop as soon
// as ba is low, writes may continue for MAX_BA_WRITES phi cycles after ba
// falls, and nothing is issued while aec is low.
//
// Ports
//   clk_dot4x  : sole clock, all logic on posedge
//   rst        : synchronous, active-high reset
//   clk_phi    : phi from the VIC, sampled as data
//   ba, aec    : bus arbitration inputs from the VIC
//   cmd_*      : command port (valid/ready, write flag, 6-bit address, 8-bit data)
//   rsp_valid  : one-cycle pulse when an access completes
//   rsp_rdata  : last read data (only updated by reads)
//   stall_err  : one-cycle pulse after BA_TIMEOUT consecutive blocked phi rises
//   ce, rw     : chip enable (active low) and read/write strobe to the VIC
//   adl, dbl   : address and write data to the VIC (dbl is 0 unless writing)
//   dbo_sim    : VIC data out, sampled for reads

module sim_cpu_bus_master #(
  parameter int PHI_HI_TICKS  = 16,
  parameter int SAMPLE_TICK   = 14,
  parameter int MAX_BA_WRITES = 3,
  parameter int BA_TIMEOUT    = 64
) (
  input  logic       clk_dot4x,
  input  logic       rst,
  input  logic       clk_phi,
  input  logic       ba,
  input  logic       aec,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [5:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       stall_err,
  output logic       ce,
  output logic       rw,
  output logic [5:0] adl,
  output logic [7:0] dbl,
  input  logic [7:0] dbo_sim
);

  localparam int SW = $clog2(BA_TIMEOUT + 1);
  localparam int BW = $clog2(MAX_BA_WRITES + 2);

  localparam logic [4:0]    PH_SAMPLE  = 5'(SAMPLE_TICK);
  localparam logic [4:0]    PH_LAST    = 5'(PHI_HI_TICKS - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(BA_TIMEOUT - 1);
  localparam logic [BW-1:0] BA_MAX     = BW'(MAX_BA_WRITES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  function automatic logic [4:0] phase_inc(input logic [4:0] p);
    return (p == 5'd31) ? p : p + 5'd1;
  endfunction

  function automatic logic [BW-1:0] ba_inc(input logic [BW-1:0] c);
    return (c >= BA_MAX) ? BA_MAX : c + BW'(1);
  endfunction

  state_t        state, state_nx;
  logic          phi_q;
  logic          rise;
  logic [4:0]    phase;
  logic [BW-1:0] ba_low_cnt;
  logic [SW-1:0] stall_cnt, stall_cnt_nx;
  logic          sampled, sampled_nx;
  logic          stall_err_nx;
  logic          ce_nx, rw_nx;
  logic [5:0]    adl_nx;
  logic [7:0]    dbl_nx;
  logic [7:0]    rdata_nx;
  logic          wr_q, wr_nx;
  logic [5:0]    addr_q, addr_nx;
  logic [7:0]    wdata_q, wdata_nx;
  logic          write_ok;
  logic          eligible;

  // phi is treated purely as data; phi_q is left unreset so that a reset
  // while phi is high does not fabricate a rise afterwards.
  always_ff @(posedge clk_dot4x) begin
    phi_q <= clk_phi;
  end

  assign rise = clk_phi & ~phi_q;

  // Phase counter and count of phi rises seen with ba low. Both advance
  // regardless of FSM state.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      phase      <= 5'd0;
      ba_low_cnt <= '0;
    end else begin
      if (rise) begin
        phase      <= 5'd0;
        ba_low_cnt <= ba ? '0 : ba_inc(ba_low_cnt);
      end else begin
        phase      <= phase_inc(phase);
      end
    end
  end

  // Eligibility uses ba_low_cnt before this rise's update, so after ba
  // falls exactly MAX_BA_WRITES write cycles are still granted.
  assign write_ok = ba | (ba_low_cnt < BA_MAX);
  assign eligible = rise & aec & (wr_q ? write_ok : ba);

  always_comb begin
    state_nx     = state;
    ce_nx        = ce;
    rw_nx        = rw;
    adl_nx       = adl;
    dbl_nx       = dbl;
    rdata_nx     = rsp_rdata;
    sampled_nx   = sampled;
    stall_cnt_nx = stall_cnt;
    stall_err_nx = 1'b0;
    wr_nx        = wr_q;
    addr_nx      = addr_q;
    wdata_nx     = wdata_q;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;

    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          wr_nx    = cmd_write;
          addr_nx  = cmd_addr;
          wdata_nx = cmd_wdata;
          state_nx = S_WAIT;
        end
      end

      S_WAIT: begin
        if (eligible) begin
          ce_nx        = 1'b0;
          rw_nx        = ~wr_q;
          adl_nx       = addr_q;
          dbl_nx       = wr_q ? wdata_q : 8'h00;
          stall_cnt_nx = '0;
          sampled_nx   = 1'b0;
          state_nx     = S_ACCESS;
        end else if (rise) begin
          // Blocked rise: the command stays pending even after a timeout.
          if (stall_cnt == STALL_LAST) begin
            stall_err_nx = 1'b1;
            stall_cnt_nx = '0;
          end else begin
            stall_cnt_nx = stall_cnt + SW'(1);
          end
        end
      end

      S_ACCESS: begin
        if (rise) begin
          // phi rose before the access ran its course: give the bus back now
          // and take whatever the VIC is driving if the read was not sampled.
          ce_nx    = 1'b1;
          rw_nx    = 1'b1;
          dbl_nx   = 8'h00;
          if (!wr_q && !sampled) begin
            rdata_nx = dbo_sim;
          end
          state_nx = S_DONE;
        end else begin
          if (!wr_q && !sampled && phase == PH_SAMPLE) begin
            rdata_nx   = dbo_sim;
            sampled_nx = 1'b1;
          end
          if (phase == PH_LAST) begin
            ce_nx    = 1'b1;
            rw_nx    = 1'b1;
            dbl_nx   = 8'h00;
            state_nx = S_DONE;
          end
        end
      end

      S_DONE: begin
        rsp_valid = 1'b1;
        state_nx  = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      state     <= S_IDLE;
      ce        <= 1'b1;
      rw        <= 1'b1;
      adl       <= 6'd0;
      dbl       <= 8'h00;
      rsp_rdata <= 8'h00;
      stall_err <= 1'b0;
      stall_cnt <= '0;
      sampled   <= 1'b0;
    end else begin
      state     <= state_nx;
      ce        <= ce_nx;
      rw        <= rw_nx;
      adl       <= adl_nx;
      dbl       <= dbl_nx;
      rsp_rdata <= rdata_nx;
      stall_err <= stall_err_nx;
      stall_cnt <= stall_cnt_nx;
      sampled   <= sampled_nx;
    end
  end

  // Latched command is payload only; it is always rewritten before use.
  always_ff @(posedge clk_dot4x) begin
    wr_q    <= wr_nx;
    addr_q  <= addr_nx;
    wdata_q <= wdata_nx;
  end

endmodule

// File: tb/tb_sim_cpu_bus_master.sv
// Directed testbench for sim_cpu_bus_master. Generates a 32-tick phi
// (16 high, 16 low) from clk_dot4x and walks through writes, reads, BA/AEC
// arbitration, stall timeout, reset mid-access and a stopped phi.

module tb_sim_cpu_bus_master;

  logic       clk_dot4x;
  logic       rst;
  logic       clk_phi;
  logic       ba;
  logic       aec;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       stall_err;
  logic       ce;
  logic       rw;
  logic [5:0] adl;
  logic [7:0] dbl;
  logic [7:0] dbo_sim;

  int checks      = 0;
  int failures    = 0;
  int rsp_pulses  = 0;
  int stall_pulses = 0;
  int t           = 31;
  bit phi_run     = 1'b1;

  sim_cpu_bus_master dut (
    .clk_dot4x (clk_dot4x),
    .rst       (rst),
    .clk_phi   (clk_phi),
    .ba        (ba),
    .aec       (aec),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .stall_err (stall_err),
    .ce        (ce),
    .rw        (rw),
    .adl       (adl),
    .dbl       (dbl),
    .dbo_sim   (dbo_sim)
  );

  initial begin
    clk_dot4x = 1'b0;
    forever #5 clk_dot4x = ~clk_dot4x;
  end

  // phi: high while t < 16; t wraps to 0 (phi rises) every 32 ticks.
  initial begin
    clk_phi = 1'b0;
    forever begin
      @(negedge clk_dot4x);
      if (phi_run) begin
        t = (t + 1) % 32;
        clk_phi = (t < 16);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_dot4x);
      if (rsp_valid === 1'b1) rsp_pulses++;
      if (stall_err === 1'b1) stall_pulses++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_dot4x);
    #1;
  endtask

  // Returns 1 time unit after the dot4x edge on which the DUT sees phi rise.
  task automatic wait_rise();
    int n;
    n = 0;
    do begin
      @(posedge clk_dot4x);
      n++;
    end while (t != 0 && n < 80);
    #1;
    if (t != 0) begin
      checks++;
      failures++;
      $error("FAIL rise_timeout observed=%0d expected=0", t);
    end
  endtask

  task automatic send(input logic wr, input logic [5:0] a, input logic [7:0] d);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    check("send_ready", 32'(cmd_ready), 32'h1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    step(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    ba        = 1'b1;
    aec       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 6'd0;
    cmd_wdata = 8'h00;
    dbo_sim   = 8'h00;
    step(4);
    check("rst_ce",        32'(ce),        32'h1);
    check("rst_rw",        32'(rw),        32'h1);
    check("rst_adl",       32'(adl),       32'h0);
    check("rst_dbl",       32'(dbl),       32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    check("rst_stall_err", 32'(stall_err), 32'h0);
    rst = 1'b0;

    // Write $20 <= $0E with the bus free.
    wait_rise();
    send(1'b1, 6'h20, 8'h0E);
    step(2);
    check("t1_ce_before_rise", 32'(ce), 32'h1);
    wait_rise();
    check("t1_ce",  32'(ce),  32'h0);
    check("t1_rw",  32'(rw),  32'h0);
    check("t1_adl", 32'(adl), 32'h20);
    check("t1_dbl", 32'(dbl), 32'h0E);
    step(15);
    check("t1_ce_ph15",  32'(ce),        32'h0);
    check("t1_rsp_ph15", 32'(rsp_valid), 32'h0);
    step(1);
    check("t1_ce_rel",  32'(ce),        32'h1);
    check("t1_rw_rel",  32'(rw),        32'h1);
    check("t1_dbl_rel", 32'(dbl),       32'h0);
    check("t1_adl_hold", 32'(adl),      32'h20);
    check("t1_rsp",     32'(rsp_valid), 32'h1);
    step(1);
    check("t1_rsp_end", 32'(rsp_valid), 32'h0);
    check("t1_ready",   32'(cmd_ready), 32'h1);

    // Read $12; data valid only from phase 14 and gone after phase 15.
    dbo_sim = 8'hAA;
    send(1'b0, 6'h12, 8'h5A);
    wait_rise();
    check("t2_ce",  32'(ce),  32'h0);
    check("t2_rw",  32'(rw),  32'h1);
    check("t2_dbl", 32'(dbl), 32'h0);
    check("t2_adl", 32'(adl), 32'h12);
    step(14);
    dbo_sim = 8'h37;
    step(1);
    check("t2_rdata_ph15", 32'(rsp_rdata), 32'h37);
    dbo_sim = 8'hFF;
    step(1);
    check("t2_rsp",   32'(rsp_valid), 32'h1);
    check("t2_rdata", 32'(rsp_rdata), 32'h37);
    check("t2_ce_rel", 32'(ce),       32'h1);
    step(1);
    check("t2_rsp_end", 32'(rsp_valid), 32'h0);

    // ba low: three writes go through, the fourth waits for ba high.
    ba = 1'b0;
    send(1'b1, 6'h01, 8'h11);
    wait_rise();
    check("t3_w1_ce",  32'(ce),  32'h0);
    check("t3_w1_adl", 32'(adl), 32'h01);
    step(16);
    check("t3_w1_rsp", 32'(rsp_valid), 32'h1);
    step(1);
    send(1'b1, 6'h02, 8'h22);
    wait_rise();
    check("t3_w2_ce",  32'(ce),  32'h0);
    check("t3_w2_adl", 32'(adl), 32'h02);
    step(17);
    send(1'b1, 6'h03, 8'h33);
    wait_rise();
    check("t3_w3_ce",  32'(ce),  32'h0);
    check("t3_w3_adl", 32'(adl), 32'h03);
    step(17);
    send(1'b1, 6'h04, 8'h44);
    wait_rise();
    check("t3_w4_blocked", 32'(ce), 32'h1);
    step(17);
    check("t3_w4_pending", 32'(cmd_ready), 32'h0);
    wait_rise();
    check("t3_w4_blocked2", 32'(ce), 32'h1);
    ba = 1'b1;
    wait_rise();
    check("t3_w4_ce",  32'(ce),  32'h0);
    check("t3_w4_adl", 32'(adl), 32'h04);
    check("t3_w4_dbl", 32'(dbl), 32'h44);
    step(16);
    check("t3_w4_rsp", 32'(rsp_valid), 32'h1);
    step(1);

    // Read while ba low never issues; 64th blocked rise raises stall_err.
    ba = 1'b0;
    dbo_sim = 8'h5C;
    send(1'b0, 6'h2A, 8'h00);
    wait_rise();
    check("t5_rd_blocked", 32'(ce),        32'h1);
    check("t5_no_stall1",  32'(stall_err), 32'h0);
    for (int i = 2; i <= 63; i++) wait_rise();
    check("t5_ce_63",       32'(ce),    32'h1);
    check("t5_pulses_63",   32'(stall_pulses), 32'h0);
    wait_rise();
    check("t5_stall_64",    32'(stall_err), 32'h1);
    step(1);
    check("t5_stall_end",   32'(stall_err), 32'h0);
    check("t5_pulses_once", 32'(stall_pulses), 32'h1);
    check("t5_still_pend",  32'(cmd_ready), 32'h0);
    ba = 1'b1;
    wait_rise();
    check("t5_rd_ce",  32'(ce),  32'h0);
    check("t5_rd_rw",  32'(rw),  32'h1);
    check("t5_rd_adl", 32'(adl), 32'h2A);
    step(16);
    check("t5_rsp",   32'(rsp_valid), 32'h1);
    check("t5_rdata", 32'(rsp_rdata), 32'h5C);
    step(1);

    // aec low at the rise holds off a write for one phi cycle.
    aec = 1'b0;
    send(1'b1, 6'h3F, 8'hA5);
    wait_rise();
    check("t4_aec_blocked", 32'(ce), 32'h1);
    aec = 1'b1;
    wait_rise();
    check("t4_ce",  32'(ce),  32'h0);
    check("t4_adl", 32'(adl), 32'h3F);
    check("t4_dbl", 32'(dbl), 32'hA5);
    step(16);
    check("t4_rsp", 32'(rsp_valid), 32'h1);
    step(1);

    // Reset in the middle of a read drops it without a response.
    dbo_sim = 8'h99;
    send(1'b0, 6'h15, 8'h00);
    wait_rise();
    check("t6_ce_issue", 32'(ce), 32'h0);
    step(5);
    rst = 1'b1;
    step(1);
    check("t6_ce",        32'(ce),        32'h1);
    check("t6_rw",        32'(rw),        32'h1);
    check("t6_cmd_ready", 32'(cmd_ready), 32'h1);
    check("t6_rsp_valid", 32'(rsp_valid), 32'h0);
    check("t6_rsp_rdata", 32'(rsp_rdata), 32'h0);
    rst = 1'b0;
    step(40);
    check("t6_no_rsp", 32'(rsp_pulses), 32'h8);
    check("t6_ce_idle", 32'(ce), 32'h1);

    // phi stopped: a pending write waits until phi rises again.
    wait_rise();
    step(20);
    phi_run = 1'b0;
    send(1'b1, 6'h07, 8'h77);
    step(100);
    check("t7_ce_stopped",  32'(ce),        32'h1);
    check("t7_pending",     32'(cmd_ready), 32'h0);
    phi_run = 1'b1;
    wait_rise();
    check("t7_ce",  32'(ce),  32'h0);
    check("t7_adl", 32'(adl), 32'h07);
    step(16);
    check("t7_rsp", 32'(rsp_valid), 32'h1);
    step(2);
    check("t7_rsp_total", 32'(rsp_pulses), 32'h9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
